// File: rtl/ospi_xfer_ctrl_if.sv
// Host/flash-side bundle for ospi_xfer_ctrl: descriptor handshake, write/read byte streams,
// completion pulse and the octal flash pins.
interface ospi_xfer_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [4:0]  req_dummy;
    logic [7:0]  req_len;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        ospi_cs_n;
    logic        ospi_sclk;
    logic [7:0]  dq_o;
    logic        dq_oe;
    logic [7:0]  dq_i;

    modport master (
        output req_valid, req_cmd, req_addr, req_rw, req_dummy, req_len,
        output wr_data, wr_valid, dq_i,
        input  req_ready, wr_ready, rd_data, rd_valid, done,
        input  ospi_cs_n, ospi_sclk, dq_o, dq_oe
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_rw, req_dummy, req_len,
        input  wr_data, wr_valid, dq_i,
        output req_ready, wr_ready, rd_data, rd_valid, done,
        output ospi_cs_n, ospi_sclk, dq_o, dq_oe
    );
endinterface

// File: rtl/ospi_xfer_ctrl.sv
// Single-master OSPI transaction sequencer: CMD, ADDR, DUMMY, DATA phases in SDR octal mode,
// sclk = clk/2 with stretching while write data is unavailable.
// Optional feature macro: OSPI_CMD_DUAL_BYTE_EN (two-beat opcode: cmd then ~cmd).
module ospi_xfer_ctrl #(
    parameter int unsigned ADDR_BYTES  = 4,
    parameter int unsigned CS_HIGH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    ospi_xfer_ctrl_if.slave bus
);

`ifdef OSPI_CMD_DUAL_BYTE_EN
    localparam int unsigned CMD_BEATS = 2;
`else
    localparam int unsigned CMD_BEATS = 1;
`endif
    localparam int unsigned GAP_W = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD, S_GAP
    } state_t;

    state_t           state_q, state_d, nxt_state;
    logic [7:0]       cnt_q, cnt_d, nxt_cnt;
    logic             stall_q, stall_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [31:0]      addr_q, addr_d;
    logic             rw_q, rw_d;
    logic [4:0]       dummy_q, dummy_d;
    logic [7:0]       len_q, len_d;
    logic             req_ready_q, req_ready_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic [7:0]       dq_o_q, dq_o_d;
    logic             dq_oe_q, dq_oe_d;
    logic             wr_ready_q, wr_ready_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             done_q, done_d;
    logic             nxt_wr;
    logic [7:0]       addr_byte;

    assign bus.req_ready = req_ready_q;
    assign bus.ospi_cs_n = cs_n_q;
    assign bus.ospi_sclk = sclk_q;
    assign bus.dq_o      = dq_o_q;
    assign bus.dq_oe     = dq_oe_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.done      = done_q;

    // Phase and remaining-beat count of the beat that follows the current one
    always_comb begin
        nxt_state = S_HOLD;
        nxt_cnt   = '0;
        if (cnt_q != 8'd0) begin
            nxt_state = state_q;
            nxt_cnt   = cnt_q - 8'd1;
        end else begin
            case (state_q)
                S_CMD: begin
                    nxt_state = S_ADDR;
                    nxt_cnt   = 8'(ADDR_BYTES - 1);
                end
                S_ADDR: begin
                    if (dummy_q != 5'd0) begin
                        nxt_state = S_DUMMY;
                        nxt_cnt   = 8'(dummy_q) - 8'd1;
                    end else if (len_q != 8'd0) begin
                        nxt_state = S_DATA;
                        nxt_cnt   = len_q - 8'd1;
                    end
                end
                S_DUMMY: begin
                    if (len_q != 8'd0) begin
                        nxt_state = S_DATA;
                        nxt_cnt   = len_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign nxt_wr    = (nxt_state == S_DATA) && !rw_q;
    assign addr_byte = 8'(addr_q >> {nxt_cnt[1:0], 3'b000});

    // Next-state and next-output logic; beats advance on the sclk-high cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_d     = stall_q;
        gap_d       = gap_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        dummy_d     = dummy_q;
        len_d       = len_q;
        req_ready_d = req_ready_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        wr_ready_d  = wr_ready_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    cmd_d       = bus.req_cmd;
                    addr_d      = bus.req_addr;
                    rw_d        = bus.req_rw;
                    dummy_d     = bus.req_dummy;
                    len_d       = bus.req_len;
                    state_d     = S_CMD;
                    cnt_d       = 8'(CMD_BEATS - 1);
                    stall_d     = 1'b0;
                    req_ready_d = 1'b0;
                    cs_n_d      = 1'b0;
                    sclk_d      = 1'b0;
                    dq_o_d      = bus.req_cmd;
                    dq_oe_d     = 1'b1;
                    wr_ready_d  = 1'b0;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (stall_q) begin
                    // sclk held low until the write byte arrives; beat starts next cycle
                    if (bus.wr_valid) begin
                        stall_d    = 1'b0;
                        wr_ready_d = 1'b0;
                        dq_o_d     = bus.wr_data;
                        dq_oe_d    = 1'b1;
                    end
                end else if (!sclk_q) begin
                    sclk_d     = 1'b1;
                    wr_ready_d = nxt_wr;
                end else begin
                    sclk_d = 1'b0;
                    if (state_q == S_DATA && rw_q) begin
                        rd_data_d  = bus.dq_i;
                        rd_valid_d = 1'b1;
                    end
                    if (nxt_state == S_HOLD) begin
                        state_d    = S_HOLD;
                        cnt_d      = '0;
                        dq_oe_d    = 1'b0;
                        wr_ready_d = 1'b0;
                    end else begin
                        state_d = nxt_state;
                        cnt_d   = nxt_cnt;
                        if (nxt_wr && !bus.wr_valid) begin
                            stall_d = 1'b1;
                        end else begin
                            wr_ready_d = 1'b0;
                            case (nxt_state)
                                S_CMD: begin
                                    dq_o_d  = ~cmd_q;
                                    dq_oe_d = 1'b1;
                                end
                                S_ADDR: begin
                                    dq_o_d  = addr_byte;
                                    dq_oe_d = 1'b1;
                                end
                                S_DUMMY: dq_oe_d = 1'b0;
                                default: begin
                                    if (rw_q) begin
                                        dq_oe_d = 1'b0;
                                    end else begin
                                        dq_o_d  = bus.wr_data;
                                        dq_oe_d = 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
            S_HOLD: begin
                cs_n_d  = 1'b1;
                done_d  = 1'b1;
                state_d = S_GAP;
                gap_d   = GAP_W'(CS_HIGH_CYC - 1);
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, descriptor and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stall_q     <= 1'b0;
            gap_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            dummy_q     <= '0;
            len_q       <= '0;
            req_ready_q <= 1'b1;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall_d;
            gap_q       <= gap_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            dummy_q     <= dummy_d;
            len_q       <= len_d;
            req_ready_q <= req_ready_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            wr_ready_q  <= wr_ready_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_ospi_xfer_ctrl.sv
// Testbench for ospi_xfer_ctrl: drives descriptors, plays write source and flash read responder,
// and compares observed beats, read bytes and timing against a transaction-level model.
// Honours OSPI_CMD_DUAL_BYTE_EN for the expected command beats.
module tb_ospi_xfer_ctrl;

    localparam int AB  = 4;
    localparam int CSH = 2;
`ifdef OSPI_CMD_DUAL_BYTE_EN
    localparam int C_BEATS = 2;
`else
    localparam int C_BEATS = 1;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [7:0] tx  [256];
    logic [7:0] rx  [256];
    int         dly [256];

    ospi_xfer_ctrl_if bus();

    ospi_xfer_ctrl #(.ADDR_BYTES(AB), .CS_HIGH_CYC(CSH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_addr  = '0;
        bus.req_rw    = 1'b0;
        bus.req_dummy = '0;
        bus.req_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.dq_i      = '0;
    endtask

    task automatic clear_data();
        for (int i = 0; i < 256; i++) begin
            tx[i]  = 8'($urandom);
            rx[i]  = 8'($urandom);
            dly[i] = 0;
        end
    endtask

    // One complete transaction, checked against the model built from the descriptor
    task automatic run_xfer(input string nm, input logic [7:0] cmd, input logic [31:0] addr,
                            input logic rw, input logic [4:0] dummy, input logic [7:0] len);
        logic       e_oe [$];
        logic [7:0] e_dat[$];
        logic       e_chk[$];
        logic       o_oe [$];
        logic [7:0] o_dat[$];
        logic [7:0] o_rd [$];
        logic [7:0] ab;
        int t, wi, wt, stall_sum, exp_lat, done_t, n, k, nb, nd, ln;
        logic prev_hs, cs_err, prev_sclk, prev_cs, gap_err;

        nd = int'(dummy);
        ln = int'(len);
        t  = 0;
        while (bus.req_ready !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        if (bus.req_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL %s ready_wait: req_ready=%b want 1 within 200 cycles", nm, bus.req_ready);
            return;
        end

        e_oe.push_back(1'b1); e_dat.push_back(cmd); e_chk.push_back(1'b1);
        if (C_BEATS == 2) begin
            e_oe.push_back(1'b1); e_dat.push_back(~cmd); e_chk.push_back(1'b1);
        end
        for (int i = AB - 1; i >= 0; i--) begin
            ab = 8'(addr >> (8 * i));
            e_oe.push_back(1'b1); e_dat.push_back(ab); e_chk.push_back(1'b1);
        end
        for (int i = 0; i < nd; i++) begin
            e_oe.push_back(1'b0); e_dat.push_back(8'h00); e_chk.push_back(1'b0);
        end
        stall_sum = 0;
        for (int i = 0; i < ln; i++) begin
            if (rw) begin
                e_oe.push_back(1'b0); e_dat.push_back(8'h00); e_chk.push_back(1'b0);
            end else begin
                e_oe.push_back(1'b1); e_dat.push_back(tx[i]); e_chk.push_back(1'b1);
                stall_sum += dly[i];
            end
        end
        exp_lat = 2 * (C_BEATS + AB + nd + ln) + 2 + stall_sum;

        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_addr  = addr;
        bus.req_rw    = rw;
        bus.req_dummy = dummy;
        bus.req_len   = len;
        bus.wr_valid  = 1'b0;
        bus.dq_i      = 8'($urandom);
        step();
        t = 1;

        total++;
        if ({bus.ospi_cs_n, bus.ospi_sclk, bus.dq_oe, bus.req_ready, bus.dq_o} !== {1'b0, 1'b0, 1'b1, 1'b0, cmd}) begin
            bad++;
            $display("FAIL %s first_cycle: cs_n/sclk/oe/rdy/dq=%b/%b/%b/%b/%h want 0/0/1/0/%h",
                     nm, bus.ospi_cs_n, bus.ospi_sclk, bus.dq_oe, bus.req_ready, bus.dq_o, cmd);
        end

        wi = 0;
        wt = dly[0];
        prev_hs   = 1'b0;
        done_t    = -1;
        cs_err    = 1'b0;
        prev_sclk = 1'b1;
        prev_cs   = 1'b1;
        while (t < 3000) begin
            if (prev_hs) begin
                wi++;
                wt = (wi < ln) ? dly[wi] : 0;
            end
            if (bus.rd_valid === 1'b1) o_rd.push_back(bus.rd_data);
            if (bus.done === 1'b1) begin
                done_t = t;
                break;
            end
            if (bus.ospi_cs_n !== 1'b0) cs_err = 1'b1;
            if (bus.ospi_sclk === 1'b1) begin
                o_oe.push_back(bus.dq_oe);
                o_dat.push_back(bus.dq_o);
                k = o_oe.size() - 1 - (C_BEATS + AB + nd);
                if (rw && k >= 0 && k < ln) bus.dq_i = rx[k];
                else                         bus.dq_i = 8'($urandom);
            end else begin
                bus.dq_i = 8'($urandom);
            end
            // requests while busy carry garbage and must be ignored
            bus.req_valid = 1'($urandom);
            bus.req_cmd   = 8'($urandom);
            bus.req_addr  = $urandom;
            bus.req_rw    = 1'($urandom);
            bus.req_dummy = 5'($urandom);
            bus.req_len   = 8'($urandom);
            if (bus.wr_ready === 1'b1) begin
                if (wt > 0) begin
                    bus.wr_valid = 1'b0;
                    bus.wr_data  = 8'($urandom);
                    wt--;
                end else begin
                    bus.wr_valid = 1'b1;
                    bus.wr_data  = (wi < ln) ? tx[wi] : 8'hEE;
                end
            end else begin
                bus.wr_valid = 1'($urandom);
                bus.wr_data  = 8'($urandom);
            end
            prev_hs   = bus.wr_valid && (bus.wr_ready === 1'b1);
            prev_sclk = bus.ospi_sclk;
            prev_cs   = bus.ospi_cs_n;
            step();
            t++;
        end
        bus.req_valid = 1'b0;
        bus.wr_valid  = 1'b0;

        if (done_t < 0) begin
            total++; bad++;
            $display("FAIL %s done_timeout: no done within %0d cycles, want at %0d", nm, t, exp_lat);
            return;
        end

        total++;
        if (done_t != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, done_t, exp_lat);
        end
        total++;
        if (cs_err !== 1'b0) begin
            bad++;
            $display("FAIL %s cs_low: cs_n rose before done (got %b want 0)", nm, cs_err);
        end
        total++;
        if ({prev_sclk, prev_cs} !== 2'b00) begin
            bad++;
            $display("FAIL %s hold: sclk/cs_n before done=%b/%b want 0/0", nm, prev_sclk, prev_cs);
        end
        nb = o_oe.size();
        total++;
        if (nb != e_oe.size()) begin
            bad++;
            $display("FAIL %s beat_count: got %0d want %0d", nm, nb, e_oe.size());
        end
        if (e_oe.size() < nb) nb = e_oe.size();
        for (int i = 0; i < nb; i++) begin
            total++;
            if (o_oe[i] !== e_oe[i] || (e_chk[i] && o_dat[i] !== e_dat[i])) begin
                bad++;
                $display("FAIL %s beat%0d: oe/dq=%b/%h want %b/%h", nm, i, o_oe[i], o_dat[i], e_oe[i], e_dat[i]);
            end
        end
        total++;
        if (o_rd.size() != (rw ? ln : 0)) begin
            bad++;
            $display("FAIL %s rd_count: got %0d want %0d", nm, o_rd.size(), rw ? ln : 0);
        end
        if (rw) begin
            for (int i = 0; i < ln && i < o_rd.size(); i++) begin
                total++;
                if (o_rd[i] !== rx[i]) begin
                    bad++;
                    $display("FAIL %s rd%0d: got %h want %h", nm, i, o_rd[i], rx[i]);
                end
            end
        end
        total++;
        if (wi != (rw ? 0 : ln)) begin
            bad++;
            $display("FAIL %s wr_consumed: got %0d want %0d", nm, wi, rw ? 0 : ln);
        end

        n = 0;
        gap_err = 1'b0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            if (bus.ospi_cs_n !== 1'b1) gap_err = 1'b1;
            if (n > 0 && bus.done !== 1'b0) gap_err = 1'b1;
            step();
            n++;
        end
        total++;
        if (n != CSH) begin
            bad++;
            $display("FAIL %s gap_len: cs_n high %0d cycles before req_ready, want %0d", nm, n, CSH);
        end
        total++;
        if (gap_err !== 1'b0) begin
            bad++;
            $display("FAIL %s gap_state: cs_n low or repeated done in gap (got %b want 0)", nm, gap_err);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) step();
        total++;
        if ({bus.ospi_cs_n, bus.ospi_sclk, bus.dq_oe, bus.req_ready, bus.wr_ready, bus.rd_valid, bus.done,
             bus.dq_o, bus.rd_data} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            bad++;
            $display("FAIL reset_values: cs/sclk/oe/rdy/wrr/rdv/done=%b%b%b%b%b%b%b dq=%h rd=%h want 1001000 00 00",
                     bus.ospi_cs_n, bus.ospi_sclk, bus.dq_oe, bus.req_ready, bus.wr_ready, bus.rd_valid,
                     bus.done, bus.dq_o, bus.rd_data);
        end
        #1 rst_n = 1'b1;
        repeat (3) step();
        total++;
        if ({bus.ospi_cs_n, bus.req_ready, bus.done} !== 3'b110) begin
            bad++;
            $display("FAIL reset_idle: cs/rdy/done=%b%b%b want 110", bus.ospi_cs_n, bus.req_ready, bus.done);
        end
    endtask

    task automatic test_write_basic();
        clear_data();
        tx[0] = 8'h5A;
        run_xfer("write_basic", 8'h12, 32'h00A1B2C3, 1'b0, 5'd0, 8'd1);
    endtask

    task automatic test_read_dummy();
        clear_data();
        for (int i = 0; i < 4; i++) rx[i] = 8'(8'h11 + i);
        run_xfer("read_dummy", 8'h0B, $urandom, 1'b1, 5'd8, 8'd4);
    endtask

    task automatic test_write_stall();
        clear_data();
        dly[1] = 5;
        run_xfer("write_stall", 8'h02, $urandom, 1'b0, 5'd0, 8'd3);
    endtask

    task automatic test_cmd_only();
        clear_data();
        run_xfer("cmd_only", 8'h9F, $urandom, 1'b0, 5'd0, 8'd0);
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        int   t;
        clear_data();
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        bus.req_valid = 1'b1;
        bus.req_cmd   = 8'hA5;
        bus.req_addr  = 32'hDEADBEEF;
        bus.req_rw    = 1'b0;
        bus.req_dummy = 5'd3;
        bus.req_len   = 8'd2;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 8'h33;
        step();
        bus.req_valid = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.ospi_cs_n, bus.ospi_sclk, bus.dq_oe, bus.req_ready, bus.wr_ready, bus.rd_valid, bus.done,
             bus.dq_o} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_mid_async: cs/sclk/oe/rdy/wrr/rdv/done=%b%b%b%b%b%b%b dq=%h want 1001000 00",
                     bus.ospi_cs_n, bus.ospi_sclk, bus.dq_oe, bus.req_ready, bus.wr_ready, bus.rd_valid,
                     bus.done, bus.dq_o);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 3) #1 rst_n = 1'b1;
            if (bus.done !== 1'b0) seen_done = 1'b1;
        end
        bus.wr_valid = 1'b0;
        total++;
        if (seen_done !== 1'b0 || bus.ospi_cs_n !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_quiet: done_seen=%b cs_n=%b want 0/1", seen_done, bus.ospi_cs_n);
        end
        clear_data();
        run_xfer("after_reset", 8'h05, $urandom, 1'b1, 5'd2, 8'd3);
    endtask

    task automatic test_back_to_back();
        clear_data();
        run_xfer("b2b_0", 8'h38, $urandom, 1'b0, 5'd1, 8'd2);
        clear_data();
        run_xfer("b2b_1", 8'hEB, $urandom, 1'b1, 5'd4, 8'd2);
    endtask

    task automatic test_random();
        logic [7:0] len;
        for (int n = 0; n < 8; n++) begin
            clear_data();
            for (int i = 0; i < 256; i++) dly[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            len = 8'($urandom_range(0, 10));
            run_xfer($sformatf("rand%0d", n), 8'($urandom), $urandom, 1'($urandom),
                     5'($urandom_range(0, 6)), len);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_basic();
        test_read_dummy();
        test_write_stall();
        test_cmd_only();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
